// File: rtl/logic_unit_pkg.sv
// Shared op codes, FSM state encoding and helpers for the pipelined logic unit.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_XOR   = 3'd2;
  localparam logic [2:0] OP_NAND  = 3'd3;
  localparam logic [2:0] OP_NOR   = 3'd4;
  localparam logic [2:0] OP_XNOR  = 3'd5;
  localparam logic [2:0] OP_PASSA = 3'd6;
  localparam logic [2:0] OP_NOTA  = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  // Only the associative ops can fold a running accumulator with a new operand.
  function automatic logic op_is_fold_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/logic_op_core.sv
// Combinational WIDTH-wide bitwise operator: r = op(x, z).
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] r
);

  always_comb begin
    r = '0;
    case (op)
      OP_AND:   r = x & z;
      OP_OR:    r = x | z;
      OP_XOR:   r = x ^ z;
      OP_NAND:  r = ~(x & z);
      OP_NOR:   r = ~(x | z);
      OP_XNOR:  r = ~(x ^ z);
      OP_PASSA: r = x;
      OP_NOTA:  r = ~x;
      default:  r = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: single beats produce a result one cycle after
// acceptance; accumulate packets fold every beat into one result on in_last.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             y_ones,
  output logic [CNT_W-1:0] beats,
  output logic             op_err
);

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_y_zero;
  logic             r_y_ones;
  logic [CNT_W-1:0] r_beats;
  logic             r_op_err;

  logic             w_accept;
  logic [WIDTH-1:0] w_first;
  logic [WIDTH-1:0] w_fold;
  logic             w_fold_legal;
  logic [WIDTH-1:0] w_acc_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_err_next;
  logic             w_emit;
  logic [WIDTH-1:0] w_emit_y;
  logic [CNT_W-1:0] w_emit_beats;
  logic             w_emit_err;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  logic_op_core #(.WIDTH(WIDTH)) u_first (
    .op (op),
    .x  (a),
    .z  (b),
    .r  (w_first)
  );

  logic_op_core #(.WIDTH(WIDTH)) u_fold (
    .op (op),
    .x  (r_acc),
    .z  (a),
    .r  (w_fold)
  );

  // Illegal fold ops leave the accumulator untouched and only mark the packet.
  assign w_fold_legal = op_is_fold_legal(op);
  assign w_acc_next   = w_fold_legal ? w_fold : r_acc;
  assign w_cnt_next   = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_err_next   = r_err || !w_fold_legal;

  always_comb begin
    w_emit       = 1'b0;
    w_emit_y     = w_first;
    w_emit_beats = CNT_W'(1);
    w_emit_err   = 1'b0;
    if (r_state == ST_ACC) begin
      w_emit       = w_accept && in_last;
      w_emit_y     = w_acc_next;
      w_emit_beats = w_cnt_next;
      w_emit_err   = w_err_next;
    end else begin
      w_emit       = w_accept && (!acc_en || in_last);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_y_zero    <= 1'b1;
      r_y_ones    <= 1'b0;
      r_beats     <= '0;
      r_op_err    <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_accept) begin
        if (r_state == ST_IDLE) begin
          if (acc_en) begin
            r_acc <= w_first;
            r_cnt <= CNT_W'(1);
            r_err <= 1'b0;
            if (!in_last) begin
              r_state <= ST_ACC;
            end
          end
        end else begin
          // In ACC every beat folds regardless of acc_en; only in_last closes it.
          r_acc <= w_acc_next;
          r_cnt <= w_cnt_next;
          if (in_last) begin
            r_err   <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_err   <= w_err_next;
          end
        end
      end

      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_y         <= w_emit_y;
        r_y_zero    <= (w_emit_y == '0);
        r_y_ones    <= (&w_emit_y);
        r_beats     <= w_emit_beats;
        r_op_err    <= w_emit_err;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign y_zero    = r_y_zero;
  assign y_ones    = r_y_ones;
  assign beats     = r_beats;
  assign op_err    = r_op_err;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: three instances (WIDTH=1, WIDTH=8, CNT_W=2)
// share stimulus; a scoreboard checks whichever instance is selected.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       acc_en;
  logic       in_last;
  logic       out_ready;

  logic       w1_in_ready, w1_out_valid, w1_y_zero, w1_y_ones, w1_op_err;
  logic [0:0] w1_y;
  logic [7:0] w1_beats;
  logic       w8_in_ready, w8_out_valid, w8_y_zero, w8_y_ones, w8_op_err;
  logic [7:0] w8_y;
  logic [7:0] w8_beats;
  logic       c2_in_ready, c2_out_valid, c2_y_zero, c2_y_ones, c2_op_err;
  logic [7:0] c2_y;
  logic [1:0] c2_beats;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(1), .CNT_W(8)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w1_in_ready),
    .a(a[0:0]), .b(b[0:0]), .op(op), .acc_en(acc_en), .in_last(in_last),
    .out_valid(w1_out_valid), .out_ready(out_ready), .y(w1_y),
    .y_zero(w1_y_zero), .y_ones(w1_y_ones), .beats(w1_beats), .op_err(w1_op_err)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w8_in_ready),
    .a(a), .b(b), .op(op), .acc_en(acc_en), .in_last(in_last),
    .out_valid(w8_out_valid), .out_ready(out_ready), .y(w8_y),
    .y_zero(w8_y_zero), .y_ones(w8_y_ones), .beats(w8_beats), .op_err(w8_op_err)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c2_in_ready),
    .a(a), .b(b), .op(op), .acc_en(acc_en), .in_last(in_last),
    .out_valid(c2_out_valid), .out_ready(out_ready), .y(c2_y),
    .y_zero(c2_y_zero), .y_ones(c2_y_ones), .beats(c2_beats), .op_err(c2_op_err)
  );

  int sel = 1;
  logic       mon_in_ready, mon_valid, mon_zero, mon_ones, mon_err;
  logic [7:0] mon_y, mon_beats;

  always_comb begin
    mon_in_ready = w8_in_ready;
    mon_valid    = w8_out_valid;
    mon_y        = w8_y;
    mon_zero     = w8_y_zero;
    mon_ones     = w8_y_ones;
    mon_beats    = w8_beats;
    mon_err      = w8_op_err;
    if (sel == 0) begin
      mon_in_ready = w1_in_ready;
      mon_valid    = w1_out_valid;
      mon_y        = {7'd0, w1_y};
      mon_zero     = w1_y_zero;
      mon_ones     = w1_y_ones;
      mon_beats    = w1_beats;
      mon_err      = w1_op_err;
    end else if (sel == 2) begin
      mon_in_ready = c2_in_ready;
      mon_valid    = c2_out_valid;
      mon_y        = c2_y;
      mon_zero     = c2_y_zero;
      mon_ones     = c2_y_ones;
      mon_beats    = {6'd0, c2_beats};
      mon_err      = c2_op_err;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] y;
    logic [7:0] beats;
    logic       err;
    logic       zero;
    logic       ones;
    int         cyc;
    bit         lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] ey, input logic [7:0] eb, input logic ee, input bit lat);
    exp_t e;
    logic [7:0] mask;
    mask    = (sel == 0) ? 8'h01 : 8'hFF;
    e.y     = ey;
    e.beats = eb;
    e.err   = ee;
    e.zero  = (ey == 8'h00);
    e.ones  = (ey == mask);
    e.cyc   = cyc;
    e.lat   = lat;
    sb.push_back(e);
  endtask

  // Scoreboard: a result is taken whenever valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && mon_valid && out_ready) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_result: observed y=%0h beats=%0h with nothing expected", mon_y, mon_beats);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        $display("result sel=%0d y=%02h beats=%0d err=%0b (exp y=%02h beats=%0d err=%0b)",
                 sel, mon_y, mon_beats, mon_err, e.y, e.beats, e.err);
        chk("y", mon_y, e.y);
        chk("beats", mon_beats, e.beats);
        chk("op_err", mon_err, e.err);
        chk("y_zero", mon_zero, e.zero);
        chk("y_ones", mon_ones, e.ones);
        if (e.lat) chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic send(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] iop,
                      input logic iacc, input logic ilast);
    int t;
    t        = 0;
    in_valid = 1'b1;
    a        = ia;
    b        = ib;
    op       = iop;
    acc_en   = iacc;
    in_last  = ilast;
    @(negedge clk);
    while (!mon_in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_seen", mon_in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    acc_en   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state();
    chk("rst_out_valid", mon_valid, 0);
    chk("rst_y", mon_y, 0);
    chk("rst_y_zero", mon_zero, 1);
    chk("rst_y_ones", mon_ones, 0);
    chk("rst_beats", mon_beats, 0);
    chk("rst_op_err", mon_err, 0);
  endtask

  logic [3:0] tt [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Truth tables indexed by {a,b}.
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
    tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b1100; tt[7] = 4'b0011;

    rst = 1'b1; out_ready = 1'b1; a = '0; b = '0; op = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    sel = 1;
    chk_reset_state();
    chk("rst_in_ready", mon_in_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Exhaustive single mode on the 1-bit instance, back to back.
    sel = 0;
    for (int o = 0; o < 8; o++) begin
      for (int ab = 0; ab < 4; ab++) begin
        logic [1:0] abv;
        abv = 2'(ab);
        send({7'd0, abv[1]}, {7'd0, abv[0]}, 3'(o), 1'b0, 1'b0);
        push({7'd0, tt[o][ab]}, 8'd1, 1'b0, 1'b1);
      end
    end
    idle();
    wait_drain();

    // Output stall holds the result and blocks input.
    sel = 1;
    out_ready = 1'b0;
    send(8'hF0, 8'hFF, 3'd2, 1'b0, 1'b0);
    push(8'h0F, 8'd1, 1'b0, 1'b0);
    idle();
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", mon_valid, 1);
      chk("stall_in_ready", mon_in_ready, 0);
      chk("stall_y", mon_y, 8'h0F);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();
    chk("stall_no_dup", mon_valid, 0);

    // Accumulate AND over four beats; beat 3 uses acc_en=0 inside the packet.
    send(8'hFF, 8'hFF, 3'd0, 1'b1, 1'b0);
    chk("acc_quiet1", mon_valid, 0);
    send(8'hF7, 8'h00, 3'd0, 1'b1, 1'b0);
    chk("acc_quiet2", mon_valid, 0);
    send(8'h7F, 8'h00, 3'd0, 1'b0, 1'b0);
    chk("acc_quiet3", mon_valid, 0);
    send(8'hFE, 8'h00, 3'd0, 1'b1, 1'b1);
    push(8'h76, 8'd4, 1'b0, 1'b1);
    idle();
    wait_drain();

    // Illegal NAND mid-packet: accumulator holds, error flag is sticky.
    send(8'h0F, 8'hFF, 3'd0, 1'b1, 1'b0);
    send(8'h00, 8'h00, 3'd3, 1'b1, 1'b0);
    send(8'h0F, 8'h00, 3'd0, 1'b1, 1'b1);
    push(8'h0F, 8'd3, 1'b1, 1'b1);
    send(8'h00, 8'h00, 3'd1, 1'b0, 1'b0);
    push(8'h00, 8'd1, 1'b0, 1'b1);
    idle();
    wait_drain();

    // Beat counter saturation on the CNT_W=2 instance.
    sel = 2;
    send(8'h01, 8'h00, 3'd1, 1'b1, 1'b0);
    send(8'h02, 8'h00, 3'd1, 1'b1, 1'b0);
    send(8'h04, 8'h00, 3'd1, 1'b1, 1'b0);
    send(8'h08, 8'h00, 3'd1, 1'b1, 1'b0);
    send(8'h10, 8'h00, 3'd1, 1'b1, 1'b1);
    push(8'h1F, 8'd3, 1'b0, 1'b1);
    idle();
    wait_drain();

    // Reset in the middle of a packet discards the partial accumulation.
    sel = 1;
    send(8'hFF, 8'hFF, 3'd0, 1'b1, 1'b0);
    send(8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_state();
    rst = 1'b0;
    send(8'hFF, 8'h0F, 3'd0, 1'b1, 1'b1);
    push(8'h0F, 8'd1, 1'b0, 1'b1);
    idle();
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
